// File: rtl/shift_pkg.sv
// Shared opcode encoding and small decode helpers for the shift/rotate datapath unit.
package shift_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_PASS = 3'b000;
  localparam op_t OP_LSL  = 3'b001;
  localparam op_t OP_LSR  = 3'b010;
  localparam op_t OP_ASR  = 3'b011;
  localparam op_t OP_ROL  = 3'b100;
  localparam op_t OP_ROR  = 3'b101;

  // Opcodes above OP_ROR are reserved and reported as errors.
  function automatic logic op_legal(input op_t op);
    return (op <= OP_ROR);
  endfunction

  function automatic logic op_is_left(input op_t op);
    return (op == OP_LSL) || (op == OP_ROL);
  endfunction

  function automatic logic op_is_rot(input op_t op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter: log2(WIDTH) right-shift levels, with left ops
// handled by bit-reversing the operand on the way in and the result on the way out.
module shift_core
  import shift_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  op_t                op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               err
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic               legal;
  logic               active;
  logic               left;
  logic               rot;
  logic               fill;
  logic [WIDTH-1:0]   b_dir;
  logic [WIDTH-1:0]   r_dir;
  logic [SHAMT_W-1:0] carry_idx;

  assign legal     = op_legal(op);
  assign active    = legal && (op != OP_PASS);
  assign left      = op_is_left(op);
  assign rot       = op_is_rot(op);
  assign fill      = (op == OP_ASR) && b[WIDTH-1];
  assign b_dir     = left ? bit_rev(b) : b;
  assign carry_idx = shamt - {{(SHAMT_W-1){1'b0}}, 1'b1};

  // Level l shifts right by 2**l; rotates wrap the low bits, shifts insert fill.
  for (genvar l = 0; l < SHAMT_W; l++) begin : g_lvl
    localparam int S = 1 << l;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    if (l == 0) begin : g_first
      assign din = b_dir;
    end else begin : g_next
      assign din = g_lvl[l-1].dout;
    end
    assign dout = !shamt[l] ? din :
                  rot       ? {din[S-1:0], din[WIDTH-1:S]} :
                              {{S{fill}}, din[WIDTH-1:S]};
  end

  assign r_dir = g_lvl[SHAMT_W-1].dout;

  always_comb begin
    result = b;
    carry  = 1'b0;
    err    = !legal;
    if (active) begin
      result = left ? bit_rev(r_dir) : r_dir;
      if (shamt != '0) begin
        // For left shifts b_dir is reversed, so index n-1 selects b[WIDTH-n].
        if (rot) carry = left ? result[0] : result[WIDTH-1];
        else     carry = b_dir[carry_idx];
      end
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shift/rotate unit: S1 holds the operands, S2 holds the
// result and flags, with full valid/ready backpressure on both sides.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_carry,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_err
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1.
  // Once valid is raised its payload holds until that transfer; ready may depend
  // combinationally on the downstream ready but never on the upstream valid.

  logic               s1_valid;
  op_t                s1_op;
  logic [SHAMT_W-1:0] s1_shamt;
  logic [WIDTH-1:0]   s1_b;

  logic               s2_valid;
  logic [WIDTH-1:0]   s2_result;
  logic               s2_carry;
  logic               s2_err;

  logic               s2_load;
  logic               s1_load;
  logic [WIDTH-1:0]   core_result;
  logic               core_carry;
  logic               core_err;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_ready;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op),
    .shamt  (s1_shamt),
    .b      (s1_b),
    .result (core_result),
    .carry  (core_carry),
    .err    (core_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_PASS;
      s1_shamt <= '0;
      s1_b     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op    <= in_op;
        s1_shamt <= in_shamt;
        s1_b     <= in_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_carry  <= core_carry;
        s2_err    <= core_err;
      end
    end
  end

  // Zero is qualified by s2_valid so an empty, freshly reset stage reads as 0.
  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_carry  = s2_carry;
  assign out_zero   = s2_valid && (s2_result == '0);
  assign out_neg    = s2_result[WIDTH-1];
  assign out_err    = s2_err;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed and random stimulus for shift_unit_pipe with an expected-result
// queue checked against an independent behavioural model.
module tb_shift_unit_pipe;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [SW-1:0] in_shamt;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_carry;
  logic          out_zero;
  logic          out_neg;
  logic          out_err;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         e;
  } res_t;

  typedef struct packed {
    logic        lat;
    logic [31:0] acc;
    res_t        r;
  } sb_t;

  sb_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic lat_on = 1'b0;

  shift_unit_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_shamt   (in_shamt),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_err    (out_err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [2:0] op, input int n, input logic [W-1:0] b);
    res_t m;
    m.res = b;
    m.c   = 1'b0;
    m.e   = 1'b0;
    case (op)
      3'd1: begin m.res = b << n;  if (n > 0) m.c = b[W-n]; end
      3'd2: begin m.res = b >> n;  if (n > 0) m.c = b[n-1]; end
      3'd3: begin m.res = W'($signed(b) >>> n); if (n > 0) m.c = b[n-1]; end
      3'd4: if (n > 0) begin m.res = (b << n) | (b >> (W-n)); m.c = m.res[0]; end
      3'd5: if (n > 0) begin m.res = (b >> n) | (b << (W-n)); m.c = m.res[W-1]; end
      3'd6, 3'd7: m.e = 1'b1;
      default: ;
    endcase
    m.z = (m.res == '0);
    m.n = m.res[W-1];
    return m;
  endfunction

  // Scoreboard monitor: pops one expectation per output transfer
  task automatic monitor();
    sb_t  s;
    res_t got;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        got = {out_result, out_carry, out_zero, out_neg, out_err};
        total++;
        assert (exp_q.size() > 0) else begin
          bad++; $error("FAIL extra_out got result=%h want no output", out_result);
        end
        if (exp_q.size() > 0) begin
          s = exp_q.pop_front();
          total++;
          assert (got === s.r) else begin
            bad++;
            $error("FAIL result got res=%h c=%b z=%b n=%b e=%b want res=%h c=%b z=%b n=%b e=%b",
                   got.res, got.c, got.z, got.n, got.e, s.r.res, s.r.c, s.r.z, s.r.n, s.r.e);
          end
          if (s.lat) begin
            total++;
            assert (cyc == int'(s.acc) + 2) else begin
              bad++; $error("FAIL latency got cycle=%0d want %0d", cyc, int'(s.acc) + 2);
            end
          end
        end
      end
    end
  endtask

  // Driver: present a beat and wait (bounded) for it to be accepted
  task automatic send(input logic [2:0] op, input logic [SW-1:0] n, input logic [W-1:0] b);
    int waited = 0;
    in_op    = op;
    in_shamt = n;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    total++;
    assert (in_ready === 1'b1) else begin
      bad++; $error("FAIL accept_timeout got in_ready=%b want 1", in_ready);
    end
    if (in_ready === 1'b1) exp_q.push_back({lat_on, 32'(cyc), model(op, int'(n), b)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    total++;
    assert (exp_q.size() == 0 && out_valid === 1'b0) else begin
      bad++; $error("FAIL %s got pending=%0d out_valid=%b want 0 0", tag, exp_q.size(), out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] held;
  logic [W-1:0] a_res;
  int           t0;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_shamt  = '0;
    in_b      = '0;
    out_ready = 1'b0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    total++;
    assert ({out_valid, in_ready, out_result, out_carry, out_zero, out_neg, out_err} ===
            {1'b0, 1'b1, 16'h0000, 4'b0000}) else begin
      bad++; $error("FAIL reset_state got v=%b rdy=%b res=%h flags=%b want 0 1 0000 0000",
                    out_valid, in_ready, out_result, {out_carry, out_zero, out_neg, out_err});
    end
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    lat_on    = 1'b1;

    // Every legal op on 8001 by one
    send(3'd1, 4'd1, 16'h8001);
    send(3'd2, 4'd1, 16'h8001);
    send(3'd3, 4'd1, 16'h8001);
    send(3'd4, 4'd1, 16'h8001);
    send(3'd5, 4'd1, 16'h8001);
    send(3'd0, 4'd1, 16'h8001);
    // Extreme amounts, zero amount, illegal op, zero result
    send(3'd3, 4'd15, 16'h8000);
    send(3'd2, 4'd15, 16'h8000);
    send(3'd1, 4'd15, 16'h0001);
    send(3'd1, 4'd0,  16'h1234);
    send(3'd6, 4'd3,  16'h00FF);
    send(3'd7, 4'd0,  16'h8000);
    send(3'd2, 4'd1,  16'h0001);
    send(3'd4, 4'd0,  16'hA5A5);
    drain("drain_directed");

    // Backpressure: two beats fill the pipe, the third must wait
    lat_on    = 1'b0;
    out_ready = 1'b0;
    send(3'd4, 4'd4, 16'h1234);
    send(3'd5, 4'd8, 16'h00F0);
    in_op = 3'd3; in_shamt = 4'd2; in_b = 16'h8004; in_valid = 1'b1;
    @(negedge clk);
    held  = out_result;
    a_res = model(3'd4, 4, 16'h1234).res;
    total++;
    assert (in_ready === 1'b0 && out_valid === 1'b1 && held === a_res) else begin
      bad++; $error("FAIL bp_full got rdy=%b v=%b res=%h want 0 1 %h", in_ready, out_valid, held, a_res);
    end
    repeat (3) @(negedge clk);
    total++;
    assert (in_ready === 1'b0 && out_valid === 1'b1 && out_result === held) else begin
      bad++; $error("FAIL bp_hold got rdy=%b v=%b res=%h want 0 1 %h", in_ready, out_valid, out_result, held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd3, 4'd2, 16'h8004);
    drain("drain_backpressure");

    // Streaming: 20 random beats back to back
    lat_on = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++)
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom));
    total++;
    assert (cyc - t0 == 20) else begin
      bad++; $error("FAIL stream_rate got cycles=%0d want 20", cyc - t0);
    end
    drain("drain_stream");

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    send(3'd1, 4'd3, 16'h0F0F);
    send(3'd2, 4'd3, 16'hF0F0);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    total++;
    assert ({out_valid, in_ready, out_result, out_carry, out_zero, out_neg, out_err} ===
            {1'b0, 1'b1, 16'h0000, 4'b0000}) else begin
      bad++; $error("FAIL async_reset got v=%b rdy=%b res=%h flags=%b want 0 1 0000 0000",
                    out_valid, in_ready, out_result, {out_carry, out_zero, out_neg, out_err});
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    total++;
    assert (in_ready === 1'b1 && out_valid === 1'b0) else begin
      bad++; $error("FAIL post_reset got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    send(3'd5, 4'd4, 16'h1234);
    drain("drain_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined shift/rotate unit for the datapath. It generalises the fixed 16-bit, shift-by-one operation set in three ways: configurable width, variable shift amount, and two added rotate modes. It also produces carry/zero/negative flags and reports illegal opcodes. A valid/ready handshake with full backpressure sits on both sides, so the unit can run between the register-read and writeback stages without stalling the whole core.

Parameters:
WIDTH, 16, data width in bits; must be a power of two, at least 4.
SHAMT_W, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
in_op  input  3  operation code (encoding in Behaviour)
in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
in_b  input  WIDTH  operand
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
out_result  output  WIDTH  shifted/rotated value
out_carry  output  1  last bit shifted/rotated out
out_zero  output  1  out_result == 0
out_neg  output  1  out_result[WIDTH-1]
out_err  output  1  illegal opcode flag

Behaviour:
- Op encoding:
  - 000 PASS: result = B.
  - 001 LSL: zero fill.
  - 010 LSR: zero fill.
  - 011 ASR: fill with B[WIDTH-1].
  - 100 ROL, 101 ROR.
  - 110 and 111 are illegal: result = B, carry = 0, err = 1.
- Carry out, for shamt n > 0:
  - LSL: B[WIDTH-n].
  - LSR/ASR: B[n-1].
  - ROL: result[0].
  - ROR: result[WIDTH-1].
  - PASS, illegal ops, or n = 0: carry = 0.
- Shift amount n = 0: result = B for every legal op.
- Pipeline structure, two register stages:
  - S1 captures {op, shamt, b} on an in_valid & in_ready handshake.
  - The combinational barrel shift between S1 and S2 has log2(WIDTH) mux levels.
  - S2 holds result and flags.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when out_ready is held high.
- Throughput: 1 beat/cycle.
- Stage advance rule:
  - S2 loads when S2 is empty or out_ready = 1.
  - S1 loads when S1 is empty or S1 advances into S2.
  - in_ready = !s1_valid | s2_load. This is combinational from out_ready, and there is no combinational path from in_valid.
- Backpressure: with out_ready = 0 the unit holds at most 2 beats, then deasserts in_ready.
  - out_* stay stable while out_valid = 1 and out_ready = 0.
  - No beat is dropped or duplicated.
- Simultaneous events: with a full pipe and out_ready = 1 and in_valid = 1 in the same cycle, S2 drains, S1 shifts to S2 and a new beat enters S1.
- Reset (asynchronous, any cycle including mid-stream):
  - s1_valid and s2_valid clear.
  - All data/flag registers clear to 0.
  - Outputs after reset: out_valid = 0, out_result = 0, out_carry = 0, out_zero = 0, out_neg = 0, out_err = 0, in_ready = 1.
  - In-flight beats are discarded.
- Flags out_zero and out_neg are computed from the registered result in S2.
- Consumer timing: ignore out_* when out_valid = 0. Registered values persist but carry no meaning.
- Extra shift-amount bits cannot occur because SHAMT_W is exact. ROL/ROR use amount modulo WIDTH implicitly.

Decomposition:
- Shared package shift_pkg holds:
  - op localparams: OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR.
  - the 3-bit op width constant.
- One sub-module, shift_core: purely combinational barrel shifter taking {op, shamt, b} and producing {result, carry, err}, parametrised by WIDTH. Verification can test it standalone.
- shift_unit_pipe instantiates shift_core and owns the handshake/registers.

Test Plan:
- Reset, then in_b = 16'h8001 with each legal op at shamt = 1, out_ready = 1 throughout.
  - LSL → 16'h0002, carry 1.
  - LSR → 16'h4000, carry 1.
  - ASR → 16'hC000, carry 1.
  - ROL → 16'h0003, carry 1.
  - ROR → 16'hC000, carry 1.
  - PASS → 16'h8001, carry 0.
  - Each result appears 2 cycles after acceptance.
- ASR of 16'h8000 by 15 → 16'hFFFF, neg = 1, carry = 0. LSR of 16'h8000 by 15 → 16'h0001, carry = 0. LSL of 16'h0001 by 15 → 16'h8000, neg = 1, carry = 0.
- shamt = 0 with LSL on 16'h1234 → 16'h1234, carry 0. Op 3'b110 on 16'h00FF → 16'h00FF, err = 1, carry = 0. LSR of 16'h0001 by 1 → 16'h0000, zero = 1, carry = 1.
- Backpressure: hold out_ready = 0 while sending 3 beats.
  - in_ready drops after 2 accepted beats; out_result stays stable.
  - Release out_ready: all 3 results exit in order, with no loss or duplication.
- Streaming: 20 back-to-back random beats with out_ready = 1 → one result per cycle, matching a reference model.
- Assert reset_n low mid-stream with 2 beats in flight.
  - out_valid falls immediately (asynchronously) and all outputs are 0.
  - After release, in_ready = 1 and the next beat completes with correct data.
